adc_sequencer: RTL and testbench
================================

// Module: adc_sequencer
// PURPOSE
//   Host-side controller for the SAR ADC conversion interface. Issues start pulses at a
//   programmable interval and captures each result when the ADC signals ready.
//   Averages 2**OSR_LOG2 conversions and presents the mean on a valid/ready stream.
//   Sits between the SAR ADC controller and downstream digital consumers.
// PARAMETERS
//   RESOLUTION  4   ADC result width in bits; output data width
//   OSR_LOG2    2   log2 of conversions averaged per output word (0 = no averaging)
//   PERIOD_W    16  width of period_i
//   TIMEOUT     64  max cycles in CONV waiting for adc_rdy_i before abort (>=2)
// PORTS
//   clk_i         in   1           clock, rising edge
//   rst_ni        in   1           reset, asynchronous, active-low
//   en_i          in   1           run enable (level)
//   period_i      in   PERIOD_W    idle cycles between end of one conversion and next start
//   adc_start_o   out  1           start pulse to ADC (one cycle)
//   adc_rdy_i     in   1           ADC conversion done (one-cycle strobe)
//   adc_data_i    in   RESOLUTION  ADC result, valid while adc_rdy_i=1
//   data_o        out  RESOLUTION  averaged result
//   valid_o       out  1           data_o valid
//   ready_i       in   1           downstream accept
//   overrun_o     out  1           1-cycle pulse: average dropped, output reg still full
//   timeout_o     out  1           1-cycle pulse: ADC failed to respond within TIMEOUT
//   busy_o        out  1           state != IDLE
// BEHAVIOUR
// - Reset: state IDLE; all counters, accumulator, data_o, and every output are 0.
// - FSM (registered, Moore outputs):
//   * IDLE: en_i=1 -> WAIT, wait_cnt=0.
//   * WAIT: en_i=0 -> IDLE. wait_cnt>=period_i -> START. Otherwise wait_cnt++.
//   * START: adc_start_o=1 for exactly this cycle -> CONV, to_cnt=0.
//   * CONV:
//     - adc_rdy_i=1: accumulate -> WAIT (wait_cnt=0) if en_i, else IDLE.
//     - Else, to_cnt==TIMEOUT-1: timeout_o pulse, clear acc and n -> WAIT/IDLE per en_i.
//     - Else to_cnt++.
// - period_i is sampled every WAIT cycle. period_i=0 gives START one cycle after
//   entering WAIT. Start-to-start spacing is therefore at least 3 cycles plus ADC latency.
// - adc_rdy_i outside CONV is ignored; it has no effect on acc, n, or outputs.
// - Accumulator: width RESOLUTION+OSR_LOG2; n counter width max(OSR_LOG2,1).
//   * On rdy, if n==2**OSR_LOG2-1, the word completes:
//     avg = (acc+adc_data_i) >> OSR_LOG2 (truncating); acc=0, n=0.
//   * Otherwise acc += adc_data_i, n++.
// - Output register:
//   * Loads avg and sets valid_o if (!valid_o || ready_i) in the completion cycle.
//   * Otherwise avg is dropped and overrun_o pulses in that same cycle.
//   * valid_o clears on valid_o&&ready_i with no simultaneous load.
//   * data_o is stable while valid_o&&!ready_i.
//   * Load latency: valid_o rises the cycle after the completing adc_rdy_i.
// - en_i deassert: an in-flight CONV is completed (or times out). acc and n are
//   cleared on entry to IDLE (partial average discarded). The output register is
//   untouched and still drains via ready_i.
// - Async reset mid-conversion: immediate return to reset state; no start is re-issued
//   until en_i is seen in IDLE.
// TESTING
// - OSR_LOG2=0, period_i=0, ready_i=1, ADC model returns 4'hA after 6 cycles:
//   one adc_start_o pulse per conversion; data_o=4'hA; valid_o one cycle after each rdy.
// - OSR_LOG2=2, ADC returns 3,4,5,7: one output word, data_o=4 (19>>2). valid_o only
//   after the 4th rdy. No adc_start_o within period_i+1 cycles of each rdy.
// - ready_i=0 held, OSR_LOG2=0: first result latched and held stable. Second completion
//   pulses overrun_o and data_o is unchanged. With ready_i=1 in the completion cycle, the
//   new word loads with no overrun.
// - ADC model never asserts rdy: timeout_o pulses exactly TIMEOUT cycles after the
//   adc_start_o cycle. The sequencer re-starts after period_i. valid_o stays 0.
// - en_i dropped during CONV after 2 of 4 samples: the conversion finishes, then IDLE,
//   busy_o=0. Re-enable and feed 4 samples: the average uses only the new samples.
// - rst_ni pulsed low during CONV: all outputs 0 asynchronously. adc_rdy_i arriving
//   after release is ignored while in IDLE.

Source files
------------

// File: rtl/adc_sequencer.sv
// -----------------------------------------------------------------------------
// adc_sequencer
//
// Host-side sequencer for a SAR ADC. While enabled it waits period_i idle cycles,
// issues a one-cycle start pulse, then waits for the ADC's ready strobe. It
// captures each result and averages 2**OSR_LOG2 of them. The mean (truncated) is
// presented on a valid/ready output stream.
//
// Ports
//   clk_i        in   1           clock, rising edge
//   rst_ni       in   1           asynchronous reset, active-low
//   en_i         in   1           run enable (level)
//   period_i     in   PERIOD_W    idle cycles between end of a conversion and next start
//   adc_start_o  out  1           one-cycle start pulse to the ADC
//   adc_rdy_i    in   1           ADC conversion-done strobe
//   adc_data_i   in   RESOLUTION  ADC result, qualified by adc_rdy_i
//   data_o       out  RESOLUTION  averaged result
//   valid_o      out  1           data_o holds an unconsumed word
//   ready_i      in   1           downstream accept
//   overrun_o    out  1           pulse: completed average dropped, output still full
//   timeout_o    out  1           pulse: ADC did not respond within TIMEOUT cycles
//   busy_o       out  1           sequencer is not idle
// -----------------------------------------------------------------------------
module adc_sequencer #(
    parameter int unsigned RESOLUTION = 4,
    parameter int unsigned OSR_LOG2   = 2,
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [PERIOD_W-1:0]   period_i,
    output logic                  adc_start_o,
    input  logic                  adc_rdy_i,
    input  logic [RESOLUTION-1:0] adc_data_i,
    output logic [RESOLUTION-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overrun_o,
    output logic                  timeout_o,
    output logic                  busy_o
);

    localparam int unsigned ACC_W = RESOLUTION + OSR_LOG2;
    localparam int unsigned N_W   = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT);

    localparam logic [N_W-1:0]  N_LAST  = N_W'((2 ** OSR_LOG2) - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_START = 2'd2,
        S_CONV  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [PERIOD_W-1:0]   wait_q, wait_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [N_W-1:0]        n_q, n_d;
    logic [RESOLUTION-1:0] data_q;
    logic                  valid_q;

    logic [ACC_W-1:0]      sum;
    logic                  complete;
    logic                  to_hit;
    logic                  load;

    // Mean of a full accumulator: plain truncating shift. The sum of 2**OSR_LOG2
    // RESOLUTION-bit samples always fits in ACC_W bits, so no saturation needed.
    function automatic logic [RESOLUTION-1:0] trunc_avg(input logic [ACC_W-1:0] total);
        return RESOLUTION'(total >> OSR_LOG2);
    endfunction

    assign sum = acc_q + ACC_W'(adc_data_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            to_q    <= '0;
            acc_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            to_q    <= to_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        to_d     = to_q;
        acc_d    = acc_q;
        n_d      = n_q;
        complete = 1'b0;
        to_hit   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en_i) begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                end
            end

            S_WAIT: begin
                // Leaving for IDLE discards any partial average.
                if (!en_i) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    n_d     = '0;
                end else if (wait_q >= period_i) begin
                    state_d = S_START;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            S_START: begin
                state_d = S_CONV;
                to_d    = '0;
            end

            S_CONV: begin
                if (adc_rdy_i) begin
                    if (n_q == N_LAST) begin
                        complete = 1'b1;
                        acc_d    = '0;
                        n_d      = '0;
                    end else begin
                        acc_d = sum;
                        n_d   = n_q + 1'b1;
                    end
                end else if (to_q == TO_LAST) begin
                    to_hit = 1'b1;
                    acc_d  = '0;
                    n_d    = '0;
                end else begin
                    to_d = to_q + 1'b1;
                end

                // A conversion ends either with a result or with a timeout; an
                // en_i drop during CONV only takes effect here.
                if (adc_rdy_i || to_hit) begin
                    if (en_i) begin
                        state_d = S_WAIT;
                        wait_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                        acc_d   = '0;
                        n_d     = '0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // A finished average may only enter the output register when it is empty or
    // being emptied in the same cycle; otherwise it is lost and flagged.
    assign load = complete && (!valid_q || ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= trunc_avg(sum);
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign adc_start_o = (state_q == S_START);
    assign busy_o      = (state_q != S_IDLE);
    assign timeout_o   = to_hit;
    assign overrun_o   = complete && valid_q && !ready_i;
    assign data_o      = data_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_sequencer
//
// Randomized bench for adc_sequencer. A driver plays the ADC (random latency,
// occasional no-response, stray ready strobes) and randomizes en_i / ready_i.
// A reference model works from sample lists and expected start times. It pushes
// expected averages into a queue, which a separate monitor drains on handshakes.
// -----------------------------------------------------------------------------
module tb_adc_sequencer;

    localparam int RES  = 4;
    localparam int OSR  = 2;
    localparam int PW   = 8;
    localparam int TMO  = 16;
    localparam int NAVG = 1 << OSR;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;
    logic           en       = 1'b0;
    logic [PW-1:0]  period   = '0;
    logic           adc_start;
    logic           adc_rdy  = 1'b0;
    logic [RES-1:0] adc_data = '0;
    logic [RES-1:0] data;
    logic           valid;
    logic           ready    = 1'b1;
    logic           overrun;
    logic           timeout;
    logic           busy;

    adc_sequencer #(
        .RESOLUTION (RES),
        .OSR_LOG2   (OSR),
        .PERIOD_W   (PW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .period_i    (period),
        .adc_start_o (adc_start),
        .adc_rdy_i   (adc_rdy),
        .adc_data_i  (adc_data),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .overrun_o   (overrun),
        .timeout_o   (timeout),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stimulus knobs: k_en/k_ready 0=low, 1=high, 2=random
    int k_en     = 0;
    int k_ready  = 1;
    int k_period = 0;
    int k_never  = 0;
    int k_stray  = 0;
    int fixed_q[$];
    int exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ADC behaviour and input randomization, driven 1 time unit after each edge
    initial begin : driver
        int pend;
        int p_age;
        int p_lat;
        pend  = 0;
        p_age = 0;
        p_lat = 0;
        forever begin
            @(posedge clk);
            #1;
            adc_rdy  = 1'b0;
            adc_data = RES'($urandom_range(0, (1 << RES) - 1));
            if (!rst_n) begin
                pend = 0;
            end else if (pend != 0) begin
                p_age++;
                if (p_age == p_lat) begin
                    adc_rdy = 1'b1;
                    if (fixed_q.size() > 0) adc_data = RES'(fixed_q.pop_front());
                    pend = 0;
                end else if (p_age >= TMO) begin
                    pend = 0;
                end
            end else if (adc_start) begin
                pend  = 1;
                p_age = 0;
                p_lat = (int'($urandom_range(0, 99)) < k_never) ? 0 : int'($urandom_range(1, TMO));
            end else if (k_stray != 0 && $urandom_range(0, 7) == 0) begin
                adc_rdy = 1'b1;
            end
            case (k_en)
                0:       en = 1'b0;
                1:       en = 1'b1;
                default: en = ($urandom_range(0, 9) != 0);
            endcase
            case (k_ready)
                0:       ready = 1'b0;
                1:       ready = 1'b1;
                default: ready = ($urandom_range(0, 3) != 0);
            endcase
            period = PW'(k_period);
        end
    end

    // Reference model: sample lists, expected start cycles, output slot occupancy
    initial begin : model
        bit slot_occ, in_conv, tgt_v;
        bit in_conv_p, tgt_v_p, e_start, e_busy, e_to, rdy_eff, ended, load, drop;
        int tgt, age, cyc, s, avg;
        int samples[$];
        slot_occ = 0; in_conv = 0; tgt_v = 0;
        tgt = 0; age = 0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                slot_occ = 0;
                in_conv  = 0;
                tgt_v    = 0;
                age      = 0;
                samples.delete();
                exp_q.delete();
            end else begin
                in_conv_p = in_conv;
                tgt_v_p   = tgt_v;
                e_busy    = in_conv_p || tgt_v_p;
                e_start   = tgt_v_p && (cyc == tgt);
                if (in_conv_p) age++;
                rdy_eff = in_conv_p && adc_rdy;
                e_to    = in_conv_p && !adc_rdy && (age == TMO);
                ended   = rdy_eff || e_to;
                load    = 0;
                drop    = 0;
                avg     = 0;

                chk("valid", 32'(valid), 32'(slot_occ));

                if (rdy_eff) begin
                    samples.push_back(int'(adc_data));
                    if (samples.size() == NAVG) begin
                        s = 0;
                        foreach (samples[i]) s += samples[i];
                        avg = s / NAVG;
                        samples.delete();
                        if (!slot_occ || ready) load = 1;
                        else drop = 1;
                    end
                end
                if (e_to) samples.delete();
                if (ended) in_conv = 0;
                if (slot_occ && ready) slot_occ = 0;
                if (load) begin
                    slot_occ = 1;
                    exp_q.push_back(avg);
                end

                chk("overrun", 32'(overrun), 32'(drop));
                chk("timeout", 32'(timeout), 32'(e_to));
                chk("start", 32'(adc_start), 32'(e_start));
                chk("busy", 32'(busy), 32'(e_busy));

                // Next start is due period+2 cycles after the sequencer leaves a
                // conversion or idle with en high; en low beforehand cancels it.
                if (e_start) begin
                    tgt_v   = 0;
                    in_conv = 1;
                    age     = 0;
                end else if (tgt_v_p && !en) begin
                    tgt_v = 0;
                    samples.delete();
                end
                if (ended) begin
                    if (en) begin
                        tgt_v = 1;
                        tgt   = cyc + int'(period) + 2;
                    end else begin
                        samples.delete();
                    end
                end else if (!in_conv_p && !tgt_v_p && en) begin
                    tgt_v = 1;
                    tgt   = cyc + int'(period) + 2;
                end
            end
        end
    end

    // Scoreboard monitor: pops on each output handshake, checks hold stability
    initial begin : monitor
        bit             hold_v;
        logic [RES-1:0] hold_d;
        int             e;
        hold_v = 0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 0;
            end else begin
                if (hold_v) chk("data_stable", 32'(data), 32'(hold_d));
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL word: got %0h want none (queue empty) at %0t", data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word", 32'(data), 32'(e));
                    end
                end
                hold_v = valid && !ready;
                hold_d = data;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_start", 32'(adc_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Known samples 3,4,5,7 -> 19>>2 = 4
        fixed_q  = '{3, 4, 5, 7};
        k_period = 2;
        k_en     = 1;
        n = 0;
        while (!valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("avg_valid", 32'(valid), 32'd1);
        chk("avg_3457", 32'(data), 32'd4);

        k_ready = 2; k_stray = 1; k_never = 10;
        repeat (600) @(posedge clk);
        k_ready = 0;
        repeat (300) @(posedge clk);
        k_ready = 2; k_never = 100;
        repeat (200) @(posedge clk);
        k_never = 15; k_en = 2;
        repeat (1500) @(posedge clk);

        for (int r = 0; r < 4; r++) begin
            k_en = 0;
            n = 0;
            @(negedge clk);
            while (busy && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("idle_reached", 32'(busy), 32'd0);
            k_period = int'($urandom_range(0, 6));
            k_en = 1;
            repeat (300) @(posedge clk);
        end

        // Asynchronous reset in the middle of a conversion
        k_never = 0; k_stray = 0; k_en = 1;
        n = 0;
        @(negedge clk);
        while (!adc_start && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 32'(adc_start), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        k_en = 0; k_stray = 1;
        #1;
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_data", 32'(data), 32'd0);
        chk("arst_start", 32'(adc_start), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        chk("arst_timeout", 32'(timeout), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_valid", 32'(valid), 32'd0);

        // Brief rerun, then drain
        k_stray = 0; k_en = 1; k_ready = 2; k_never = 10;
        repeat (400) @(posedge clk);
        k_en = 0; k_ready = 1;
        n = 0;
        @(negedge clk);
        while ((busy || valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", 32'(busy || valid), 32'd0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
